bit_dmem: RTL and testbench
===========================

BIT_DMEM -- requirements
Module: bit_dmem

Interface
REQ-001 Parameter: DA_W, default 12, data bit-address width.
REQ-002 Parameter: WD_W, default 16, backing-RAM word width; word index = D_A[DA_W-1:4], bit select = D_A[3:0].
REQ-003 Port: CLK  in  1  single clock, all state on rising edge.
REQ-004 Port: CLR_N  in  1  reset, asynchronous, active-low.
REQ-005 Port: D_A  in  DA_W  bit address from the CPU data stage.
REQ-006 Port: D_O  in  1  write bit (CPU accumulator).
REQ-007 Port: D_OE  in  1  read request.
REQ-008 Port: D_WE  in  1  write request.
REQ-009 Port: D_I  out  1  registered read bit to the CPU.
REQ-010 Port: D_RDY  out  1  combinational accept; low stalls the CPU.
REQ-011 Port: SCAN  in  1  one-cycle pulse at PLC scan start; latches the input image.
REQ-012 Port: IN_PIN  in  16  asynchronous physical inputs.
REQ-013 Port: OUT_PIN  out  16  registered physical outputs.

Function
REQ-014 Address map SHALL be: 0x000-0x00F input image (IN_IMG), 0x010-0x01F output register (OUT_REG), 0x020 and above backing RAM, 2^(DA_W-4) words x WD_W bits, synchronous 1-cycle read.
REQ-015 IN_PIN SHALL pass a 2-flop synchronizer; on SCAN=1, IN_IMG <= synchronized value at that edge.
REQ-016 A one-word line buffer (BUF_VALID, BUF_WA, BUF_DATA) SHALL cache the last RAM word; a hit is BUF_VALID & BUF_WA==D_A[DA_W-1:4].
REQ-017 FSM states SHALL be IDLE, FILL, LOAD; reset state IDLE.
REQ-018 In IDLE, a request (D_OE|D_WE) to the I/O region or a RAM hit SHALL give D_RDY=1 in the same cycle (accept).
REQ-019 Accepted read: D_I <= selected bit at that edge; D_I holds until the next accepted read.
REQ-020 Accepted write: I/O output region -> OUT_REG bit <= D_O; input region -> ignored, still accepted; RAM -> BUF_DATA bit and RAM word written through at the same edge.
REQ-021 D_OE and D_WE both high SHALL be treated as a write only.
REQ-022 RAM miss in IDLE: D_RDY=0, RAM read of D_A word issued, IDLE->FILL.
REQ-023 FILL: D_RDY=0, ->LOAD. LOAD: RAM data into BUF_DATA, BUF_WA <= fill address, BUF_VALID=1, D_RDY=0, ->IDLE; the retried request then hits. Miss latency: 3 stall cycles.
REQ-024 D_RDY SHALL be 0 whenever no request is present; it is never 1 outside IDLE.
REQ-025 A request dropped or changed mid-fill SHALL not abort the fill; the buffer still loads the originally latched word.
REQ-026 Only reads (not writes) SHALL update D_I; writes never touch IN_IMG.
REQ-027 OUT_PIN SHALL equal OUT_REG directly (no extra latency).

Reset
REQ-028 CLR_N=0 SHALL immediately force: state IDLE, BUF_VALID=0, BUF_WA=0, BUF_DATA=0, D_I=0, OUT_REG=0 (OUT_PIN=0), IN_IMG=0, synchronizer flops 0.
REQ-029 RAM contents SHALL not be reset.
REQ-030 Reset during FILL/LOAD SHALL abandon the fill; after release the buffer is invalid.

Verification
REQ-031 IN_PIN=16'h0005 held 3 cycles, SCAN pulse, read 0x000 then 0x001 -> D_RDY=1 immediately both, D_I=1 then 0.
REQ-032 Write D_O=1 to 0x013 -> D_RDY=1 same cycle, OUT_PIN=16'h0008 next cycle; write 0x003 -> accepted, IN_IMG unchanged.
REQ-033 Cold read 0x125 -> D_RDY=0 for 3 cycles, then 1; read 0x12A next -> D_RDY=1 with no stall (hit).
REQ-034 Write 1 to 0x240 (miss) -> 3 stall cycles then accept; read 0x340 (evicts), read 0x240 -> 3 stalls, D_I=1 (write-through verified).
REQ-035 D_OE=D_WE=1, D_O=1 to 0x011 -> OUT_PIN[1]=1, D_I unchanged.
REQ-036 CLR_N low in FILL for read 0x200 -> D_RDY=0, OUT_PIN=0, D_I=0 during reset; after release, read 0x200 takes the full 3-cycle miss.

Source files
------------

// File: rtl/bit_dmem_if.sv
//------------------------------------------------------------------------------
// Module      : bit_dmem_if
// Description : CPU data-stage bit bus between the PLC core and bit_dmem.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bit_dmem_if #(
  parameter int DA_W = 12
);
  logic [DA_W-1:0] D_A;
  logic            D_O;
  logic            D_OE;
  logic            D_WE;
  logic            D_I;
  logic            D_RDY;

  modport master (output D_A, D_O, D_OE, D_WE, input D_I, D_RDY);
  modport slave  (input D_A, D_O, D_OE, D_WE, output D_I, D_RDY);
endinterface

`default_nettype wire

// File: rtl/bit_dmem.sv
//------------------------------------------------------------------------------
// Module      : bit_dmem
// Description : Bit-addressed data memory: I/O image, output register and a
//               word RAM fronted by a one-word line buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit_dmem #(
  parameter int DA_W = 12,
  parameter int WD_W = 16
) (
  input  wire logic        CLK,
  input  wire logic        CLR_N,
  bit_dmem_if.slave        dmem,
  input  wire logic        SCAN,
  input  wire logic [15:0] IN_PIN,
  output logic      [15:0] OUT_PIN
);

  localparam int c_WA_W  = DA_W - 4;
  localparam int c_DEPTH = 1 << c_WA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0]       r_sync1;
  logic [15:0]       r_sync2;
  logic [15:0]       r_in_img;
  logic [15:0]       r_out_reg;
  logic              r_d_i;
  logic              r_buf_valid;
  logic [c_WA_W-1:0] r_buf_wa;
  logic [WD_W-1:0]   r_buf_data;
  logic [c_WA_W-1:0] r_fill_wa;
  logic [WD_W-1:0]   r_ram_q;
  logic [WD_W-1:0]   r_mem [c_DEPTH];

  logic [c_WA_W-1:0] w_wa;
  logic [3:0]        w_bit;
  logic              w_io;
  logic              w_in_rgn;
  logic              w_req;
  logic              w_hit;
  logic              w_rdy;
  logic              w_miss;
  logic              w_acc_wr;
  logic              w_acc_rd;
  logic              w_sel_bit;
  logic [WD_W-1:0]   w_buf_wdata;

  assign w_wa     = dmem.D_A[DA_W-1:4];
  assign w_bit    = dmem.D_A[3:0];
  assign w_io     = (dmem.D_A[DA_W-1:5] == '0);
  assign w_in_rgn = w_io & ~dmem.D_A[4];
  assign w_req    = dmem.D_OE | dmem.D_WE;
  assign w_hit    = r_buf_valid & (r_buf_wa == w_wa);

  // A simultaneous read and write request is a write only.
  assign w_acc_wr = w_rdy & dmem.D_WE;
  assign w_acc_rd = w_rdy & dmem.D_OE & ~dmem.D_WE;

  assign w_sel_bit = w_io ? (w_in_rgn ? r_in_img[w_bit] : r_out_reg[w_bit])
                          : r_buf_data[w_bit];

  always_comb begin
    w_buf_wdata        = r_buf_data;
    w_buf_wdata[w_bit] = dmem.D_O;
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_io || w_hit) begin
            w_rdy = 1'b1;
          end else begin
            w_miss      = 1'b1;
            w_state_nxt = ST_FILL;
          end
        end
      end
      ST_FILL: w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_in_img    <= '0;
      r_out_reg   <= '0;
      r_d_i       <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_wa    <= '0;
      r_buf_data  <= '0;
      r_fill_wa   <= '0;
    end else begin
      r_sync1 <= IN_PIN;
      r_sync2 <= r_sync1;
      if (SCAN) r_in_img <= r_sync2;
      if (w_acc_rd) r_d_i <= w_sel_bit;
      if (w_acc_wr) begin
        if (w_io) begin
          if (!w_in_rgn) r_out_reg[w_bit] <= dmem.D_O;
        end else begin
          r_buf_data <= w_buf_wdata;
        end
      end
      if (w_miss) r_fill_wa <= w_wa;
      // The fill address is latched at the miss so later request changes cannot redirect it.
      if (r_state == ST_LOAD) begin
        r_buf_valid <= 1'b1;
        r_buf_wa    <= r_fill_wa;
        r_buf_data  <= r_ram_q;
      end
    end
  end

  // Backing RAM is not reset; writes go through with the whole updated buffer word.
  always_ff @(posedge CLK) begin
    if (w_acc_wr && !w_io) r_mem[w_wa] <= w_buf_wdata;
    if (w_miss)            r_ram_q     <= r_mem[w_wa];
  end

  assign dmem.D_RDY = w_rdy;
  assign dmem.D_I   = r_d_i;
  assign OUT_PIN    = r_out_reg;

endmodule

`default_nettype wire

// File: tb/tb_bit_dmem.sv
//------------------------------------------------------------------------------
// Module      : tb_bit_dmem
// Description : Directed self-checking bench for bit_dmem.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bit_dmem;

  logic        CLK;
  logic        CLR_N;
  logic        SCAN;
  logic [15:0] IN_PIN;
  logic [15:0] OUT_PIN;
  int          n_total;
  int          n_bad;
  int          stalls;

  bit_dmem_if #(.DA_W(12)) bus ();

  bit_dmem #(.DA_W(12), .WD_W(16)) dut (
    .CLK     (CLK),
    .CLR_N   (CLR_N),
    .dmem    (bus.slave),
    .SCAN    (SCAN),
    .IN_PIN  (IN_PIN),
    .OUT_PIN (OUT_PIN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge, count stall cycles until accepted.
  task automatic do_req(input logic [11:0] a, input logic oe, input logic we,
                        input logic d, output int st);
    @(negedge CLK);
    bus.D_A  = a;
    bus.D_OE = oe;
    bus.D_WE = we;
    bus.D_O  = d;
    st = 0;
    #1;
    while (!bus.D_RDY && st < 10) begin
      @(negedge CLK);
      #1;
      st++;
    end
    @(posedge CLK);
    #1;
    bus.D_OE = 1'b0;
    bus.D_WE = 1'b0;
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    CLR_N    = 1'b1;
    SCAN     = 1'b0;
    IN_PIN   = 16'h0000;
    bus.D_A  = '0;
    bus.D_O  = 1'b0;
    bus.D_OE = 1'b0;
    bus.D_WE = 1'b0;
    #1 CLR_N = 1'b0;
    #2;
    chk("rst_out_pin", OUT_PIN, 16'h0000);
    chk("rst_d_i", {15'd0, bus.D_I}, 16'h0000);
    chk("rst_rdy", {15'd0, bus.D_RDY}, 16'h0000);
    repeat (2) @(negedge CLK);
    CLR_N = 1'b1;

    // Input image only changes on SCAN
    IN_PIN = 16'h0005;
    repeat (3) @(negedge CLK);
    do_req(12'h000, 1'b1, 1'b0, 1'b0, stalls);
    chk("pre_scan_d_i", {15'd0, bus.D_I}, 16'h0000);
    @(negedge CLK);
    SCAN = 1'b1;
    @(negedge CLK);
    SCAN = 1'b0;
    do_req(12'h000, 1'b1, 1'b0, 1'b0, stalls);
    chk("in0_stalls", stalls[15:0], 16'd0);
    chk("in0_d_i", {15'd0, bus.D_I}, 16'h0001);
    do_req(12'h001, 1'b1, 1'b0, 1'b0, stalls);
    chk("in1_stalls", stalls[15:0], 16'd0);
    chk("in1_d_i", {15'd0, bus.D_I}, 16'h0000);
    do_req(12'h002, 1'b1, 1'b0, 1'b0, stalls);
    chk("in2_d_i", {15'd0, bus.D_I}, 16'h0001);

    // Output register and ignored input-region write
    do_req(12'h013, 1'b0, 1'b1, 1'b1, stalls);
    chk("out3_stalls", stalls[15:0], 16'd0);
    chk("out3_pin", OUT_PIN, 16'h0008);
    do_req(12'h003, 1'b0, 1'b1, 1'b1, stalls);
    chk("inwr_stalls", stalls[15:0], 16'd0);
    chk("inwr_d_i_kept", {15'd0, bus.D_I}, 16'h0001);
    do_req(12'h003, 1'b1, 1'b0, 1'b0, stalls);
    chk("inwr_img", {15'd0, bus.D_I}, 16'h0000);
    do_req(12'h013, 1'b1, 1'b0, 1'b0, stalls);
    chk("out3_readback", {15'd0, bus.D_I}, 16'h0001);

    // No request means no ready, even on the I/O region
    @(negedge CLK);
    bus.D_A = 12'h000;
    #1;
    chk("idle_rdy", {15'd0, bus.D_RDY}, 16'h0000);

    // Cold miss then hit in the same word
    do_req(12'h125, 1'b1, 1'b0, 1'b0, stalls);
    chk("cold_stalls", stalls[15:0], 16'd3);
    do_req(12'h12A, 1'b1, 1'b0, 1'b0, stalls);
    chk("hit_stalls", stalls[15:0], 16'd0);
    do_req(12'h12A, 1'b0, 1'b1, 1'b1, stalls);
    chk("hitwr_stalls", stalls[15:0], 16'd0);
    do_req(12'h12A, 1'b1, 1'b0, 1'b0, stalls);
    chk("hitwr_rd", {15'd0, bus.D_I}, 16'h0001);

    // Write-through survives eviction
    do_req(12'h240, 1'b0, 1'b1, 1'b1, stalls);
    chk("wrmiss_stalls", stalls[15:0], 16'd3);
    do_req(12'h241, 1'b0, 1'b1, 1'b0, stalls);
    chk("wrhit_stalls", stalls[15:0], 16'd0);
    do_req(12'h340, 1'b1, 1'b0, 1'b0, stalls);
    chk("evict_stalls", stalls[15:0], 16'd3);
    do_req(12'h240, 1'b1, 1'b0, 1'b0, stalls);
    chk("refill_stalls", stalls[15:0], 16'd3);
    chk("wt_bit0", {15'd0, bus.D_I}, 16'h0001);
    do_req(12'h241, 1'b1, 1'b0, 1'b0, stalls);
    chk("wt_bit1", {15'd0, bus.D_I}, 16'h0000);
    do_req(12'h240, 1'b1, 1'b0, 1'b0, stalls);
    chk("wt_bit0_again", {15'd0, bus.D_I}, 16'h0001);

    // OE and WE together act as a write only
    do_req(12'h011, 1'b1, 1'b1, 1'b1, stalls);
    chk("rw_stalls", stalls[15:0], 16'd0);
    chk("rw_out_pin", OUT_PIN, 16'h000A);
    chk("rw_d_i_kept", {15'd0, bus.D_I}, 16'h0001);

    // Request dropped mid-fill still loads the latched word
    @(negedge CLK);
    bus.D_A  = 12'h300;
    bus.D_OE = 1'b1;
    @(posedge CLK);
    #1;
    bus.D_OE = 1'b0;
    bus.D_A  = 12'h400;
    @(posedge CLK);
    @(posedge CLK);
    do_req(12'h300, 1'b1, 1'b0, 1'b0, stalls);
    chk("dropfill_stalls", stalls[15:0], 16'd0);

    // Reset during fill
    @(negedge CLK);
    bus.D_A  = 12'h200;
    bus.D_OE = 1'b1;
    @(posedge CLK);
    #2;
    CLR_N = 1'b0;
    #1;
    chk("rstfill_rdy", {15'd0, bus.D_RDY}, 16'h0000);
    chk("rstfill_out_pin", OUT_PIN, 16'h0000);
    chk("rstfill_d_i", {15'd0, bus.D_I}, 16'h0000);
    @(negedge CLK);
    bus.D_OE = 1'b0;
    CLR_N    = 1'b1;
    do_req(12'h200, 1'b1, 1'b0, 1'b0, stalls);
    chk("post_rst_stalls", stalls[15:0], 16'd3);
    do_req(12'h000, 1'b1, 1'b0, 1'b0, stalls);
    chk("post_rst_img", {15'd0, bus.D_I}, 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
